// File: rtl/add_share_arb.sv
// add_share_arb: round-robin time-sharing of one external combinational
// 16-bit add/sub unit between two valid/ready requesters, each with its own
// registered response channel.
module add_share_arb #(
   parameter bit SAT = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [15:0]   req0_a,
   input  logic [15:0]   req0_b,
   input  logic          req0_sub,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [15:0]   req1_a,
   input  logic [15:0]   req1_b,
   input  logic          req1_sub,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [15:0]   rsp0_sum,
   output logic          rsp0_cout,
   output logic          rsp0_ovfl,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [15:0]   rsp1_sum,
   output logic          rsp1_cout,
   output logic          rsp1_ovfl,
   output logic [15:0]   add_a,
   output logic [15:0]   add_b,
   output logic          add_sub,
   input  logic [15:0]   add_sum,
   input  logic          add_cout,
   input  logic          add_ovfl
);

   localparam int unsigned W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t         st0, st0_nxt;
   state_t         st1, st1_nxt;
   logic           last, last_nxt;
   logic           owner;
   logic           elig0, elig1;
   logic           grant0, grant1;
   logic           cap0, cap1;
   logic [W-1:0]   sum_fix;

   // Arbitration, per-requester next state and result capture strobes
   always_comb begin
      elig0    = 1'b0;
      elig1    = 1'b0;
      grant0   = 1'b0;
      grant1   = 1'b0;
      st0_nxt  = st0;
      st1_nxt  = st1;
      last_nxt = last;
      cap0     = 1'b0;
      cap1     = 1'b0;

      elig0  = (st0 == S_IDLE) && req0_valid;
      elig1  = (st1 == S_IDLE) && req1_valid;
      // on a tie the requester not accepted last wins
      grant0 = elig0 && (!elig1 || last);
      grant1 = elig1 && (!elig0 || !last);

      if (grant0)      last_nxt = 1'b0;
      else if (grant1) last_nxt = 1'b1;

      case (st0)
         S_IDLE:  if (grant0) st0_nxt = S_ISSUE;
         S_ISSUE: st0_nxt = S_RESP;
         S_RESP:  if (rsp0_ready) st0_nxt = S_IDLE;
         default: st0_nxt = S_IDLE;
      endcase

      case (st1)
         S_IDLE:  if (grant1) st1_nxt = S_ISSUE;
         S_ISSUE: st1_nxt = S_RESP;
         S_RESP:  if (rsp1_ready) st1_nxt = S_IDLE;
         default: st1_nxt = S_IDLE;
      endcase

      cap0 = (st0 == S_ISSUE) && (owner == 1'b0);
      cap1 = (st1 == S_ISSUE) && (owner == 1'b1);
   end

   // Ready is suppressed while reset is held so nothing is accepted then
   assign req0_ready = grant0 && !rst;
   assign req1_ready = grant1 && !rst;

   // Optional saturation of a signed-overflowed sum toward the sign of A
   always_comb begin
      sum_fix = add_sum;
      if (SAT && add_ovfl) sum_fix = add_a[W-1] ? W'(16'h8000) : W'(16'h7FFF);
   end

   // State machines and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st0  <= S_IDLE;
         st1  <= S_IDLE;
         last <= 1'b1;
      end else begin
         st0  <= st0_nxt;
         st1  <= st1_nxt;
         last <= last_nxt;
      end
   end

   // Issue register: winner's operands feed the shared adder for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_a   <= '0;
         add_b   <= '0;
         add_sub <= 1'b0;
         owner   <= 1'b0;
      end else if (grant0) begin
         add_a   <= req0_a;
         add_b   <= req0_b;
         add_sub <= req0_sub;
         owner   <= 1'b0;
      end else if (grant1) begin
         add_a   <= req1_a;
         add_b   <= req1_b;
         add_sub <= req1_sub;
         owner   <= 1'b1;
      end
   end

   // Response channel 0: capture at the end of ISSUE, hold until consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp0_sum   <= '0;
         rsp0_cout  <= 1'b0;
         rsp0_ovfl  <= 1'b0;
      end else begin
         rsp0_valid <= (st0_nxt == S_RESP);
         if (cap0) begin
            rsp0_sum  <= sum_fix;
            rsp0_cout <= add_cout;
            rsp0_ovfl <= add_ovfl;
         end
      end
   end

   // Response channel 1: capture at the end of ISSUE, hold until consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp1_valid <= 1'b0;
         rsp1_sum   <= '0;
         rsp1_cout  <= 1'b0;
         rsp1_ovfl  <= 1'b0;
      end else begin
         rsp1_valid <= (st1_nxt == S_RESP);
         if (cap1) begin
            rsp1_sum  <= sum_fix;
            rsp1_cout <= add_cout;
            rsp1_ovfl <= add_ovfl;
         end
      end
   end

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: two instances (SAT=0 and SAT=1) share stimulus,
// each driving its own adder stand-in; a scoreboard tracks expected results.
module tb_add_share_arb;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovfl;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid [2];
   logic [15:0] req_a     [2];
   logic [15:0] req_b     [2];
   logic        req_sub   [2];
   logic        rsp_ready [2];

   logic        rdy       [2][2];
   logic        rsp_valid [2][2];
   logic [15:0] rsp_sum   [2][2];
   logic        rsp_cout  [2][2];
   logic        rsp_ovfl  [2][2];
   logic [15:0] add_a     [2];
   logic [15:0] add_b     [2];
   logic        add_sub   [2];
   logic [17:0] add_res   [2];

   exp_t sb [4][$];
   int   acc_log [$];
   int   acc_cyc [$];
   int   hs_cnt [2];
   bit   prev_v [2][2];
   bit   acc_flag [2];
   bit   auto_ops;
   int   cyc_n;
   int   checks;
   int   passed;

   // Combinational adder: {ovfl, cout, sum}
   function automatic logic [17:0] adder(input logic [15:0] a, input logic [15:0] b,
                                         input logic sub);
      logic [15:0] bb;
      logic [16:0] t;
      logic        ov;
      bb = sub ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + 17'(sub);
      ov = (a[15] == bb[15]) && (t[15] != a[15]);
      return {ov, t};
   endfunction

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input bit sat, input int c);
      exp_t        e;
      logic [17:0] r;
      r      = adder(a, b, sub);
      e.sum  = r[15:0];
      e.cout = r[16];
      e.ovfl = r[17];
      e.cyc  = c;
      if (sat && e.ovfl) e.sum = a[15] ? 16'h8000 : 16'h7FFF;
      return e;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign add_res[g] = adder(add_a[g], add_b[g], add_sub[g]);
      add_share_arb #(.SAT(1'(g))) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req0_valid (req_valid[0]),
         .req0_ready (rdy[g][0]),
         .req0_a     (req_a[0]),
         .req0_b     (req_b[0]),
         .req0_sub   (req_sub[0]),
         .req1_valid (req_valid[1]),
         .req1_ready (rdy[g][1]),
         .req1_a     (req_a[1]),
         .req1_b     (req_b[1]),
         .req1_sub   (req_sub[1]),
         .rsp0_valid (rsp_valid[g][0]),
         .rsp0_ready (rsp_ready[0]),
         .rsp0_sum   (rsp_sum[g][0]),
         .rsp0_cout  (rsp_cout[g][0]),
         .rsp0_ovfl  (rsp_ovfl[g][0]),
         .rsp1_valid (rsp_valid[g][1]),
         .rsp1_ready (rsp_ready[1]),
         .rsp1_sum   (rsp_sum[g][1]),
         .rsp1_cout  (rsp_cout[g][1]),
         .rsp1_ovfl  (rsp_ovfl[g][1]),
         .add_a      (add_a[g]),
         .add_b      (add_b[g]),
         .add_sub    (add_sub[g]),
         .add_sum    (add_res[g][15:0]),
         .add_cout   (add_res[g][16]),
         .add_ovfl   (add_res[g][17])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks = checks + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Scoreboard push on accept, latency check on rise, pop/compare on handshake
   task automatic monitor();
      exp_t e;
      int   idx;
      if (rst) return;
      for (int d = 0; d < 2; d++) begin
         check("one_ready", 32'(rdy[d][0] && rdy[d][1]), 32'd0);
         for (int r = 0; r < 2; r++) begin
            idx = d * 2 + r;
            if (rsp_valid[d][r] && !prev_v[d][r]) begin
               check("rsp_expected", 32'(sb[idx].size() != 0), 32'd1);
               if (sb[idx].size() != 0) check("latency", 32'(cyc_n), 32'(sb[idx][0].cyc + 2));
            end
            if (rsp_valid[d][r] && rsp_ready[r]) begin
               if (sb[idx].size() != 0) begin
                  e = sb[idx].pop_front();
                  check("sb_sum",  32'(rsp_sum[d][r]),  32'(e.sum));
                  check("sb_cout", 32'(rsp_cout[d][r]), 32'(e.cout));
                  check("sb_ovfl", 32'(rsp_ovfl[d][r]), 32'(e.ovfl));
               end else begin
                  check("sb_empty", 32'(sb[idx].size()), 32'd1);
               end
               if (d == 0) hs_cnt[r]++;
            end
            prev_v[d][r] = rsp_valid[d][r];
            if (req_valid[r] && rdy[d][r]) begin
               sb[idx].push_back(model(req_a[r], req_b[r], req_sub[r], d == 1, cyc_n));
               if (d == 0) begin
                  acc_log.push_back(r);
                  acc_cyc.push_back(cyc_n);
                  acc_flag[r] = 1'b1;
               end
            end
         end
      end
   endtask

   // One clock cycle; inputs are driven 1 time unit after the rising edge
   task automatic cyc();
      acc_flag[0] = 1'b0;
      acc_flag[1] = 1'b0;
      @(negedge clk);
      monitor();
      cyc_n++;
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         if (auto_ops && acc_flag[r]) begin
            req_a[r]   = 16'($urandom);
            req_b[r]   = 16'($urandom);
            req_sub[r] = 1'($urandom);
         end
      end
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 4; i++) sb[i].delete();
      for (int d = 0; d < 2; d++) begin
         prev_v[d][0] = 1'b0;
         prev_v[d][1] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      clear_sb();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int r);
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid[0][r]) break;
         cyc();
      end
      check("wait_rsp", 32'(rsp_valid[0][r]), 32'd1);
   endtask

   // Single directed operation with expected values for both instances
   task automatic op_test(input string tag, input int r, input logic [15:0] a,
                          input logic [15:0] b, input logic sub, input logic [15:0] s0,
                          input logic [15:0] s1, input logic c, input logic o);
      req_valid[r] = 1'b1;
      req_a[r]     = a;
      req_b[r]     = b;
      req_sub[r]   = sub;
      rsp_ready[r] = 1'b1;
      #1;
      check({tag, "_ready"}, 32'(rdy[0][r]), 32'd1);
      cyc();
      req_valid[r] = 1'b0;
      wait_valid(r);
      check({tag, "_sum0"},  32'(rsp_sum[0][r]),  32'(s0));
      check({tag, "_sum1"},  32'(rsp_sum[1][r]),  32'(s1));
      check({tag, "_cout"},  32'(rsp_cout[0][r]), 32'(c));
      check({tag, "_ovfl0"}, 32'(rsp_ovfl[0][r]), 32'(o));
      check({tag, "_ovfl1"}, 32'(rsp_ovfl[1][r]), 32'(o));
      cyc();
   endtask

   initial begin
      logic [15:0] snap_sum;
      logic        snap_cout;
      logic        snap_ovfl;
      int          done0;
      int          done1;

      checks = 0;
      passed = 0;
      cyc_n  = 0;
      auto_ops = 1'b0;
      hs_cnt[0] = 0;
      hs_cnt[1] = 0;
      rst = 1'b1;
      for (int r = 0; r < 2; r++) begin
         req_valid[r] = 1'b0;
         req_a[r]     = '0;
         req_b[r]     = '0;
         req_sub[r]   = 1'b0;
         rsp_ready[r] = 1'b0;
      end
      clear_sb();

      // Reset values
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_rsp0_valid", 32'(rsp_valid[d][0]), 32'd0);
         check("rst_rsp1_valid", 32'(rsp_valid[d][1]), 32'd0);
         check("rst_add_a",      32'(add_a[d]),        32'd0);
         check("rst_add_b",      32'(add_b[d]),        32'd0);
         check("rst_add_sub",    32'(add_sub[d]),      32'd0);
         check("rst_rsp0_sum",   32'(rsp_sum[d][0]),   32'd0);
      end
      cyc();
      cyc();
      rst = 1'b0;

      // Single op: ready in cycle 0, result in cycle 2, gone in cycle 3
      req_valid[0] = 1'b1;
      req_a[0]     = 16'h0003;
      req_b[0]     = 16'h0005;
      req_sub[0]   = 1'b0;
      rsp_ready[0] = 1'b1;
      #1;
      check("single_ready_c0", 32'(rdy[0][0]), 32'd1);
      cyc();
      req_valid[0] = 1'b0;
      #1;
      check("single_valid_c1", 32'(rsp_valid[0][0]), 32'd0);
      cyc();
      #1;
      check("single_valid_c2", 32'(rsp_valid[0][0]), 32'd1);
      check("single_sum",      32'(rsp_sum[0][0]),   32'h0008);
      check("single_cout",     32'(rsp_cout[0][0]),  32'd0);
      check("single_ovfl",     32'(rsp_ovfl[0][0]),  32'd0);
      cyc();
      #1;
      check("single_valid_c3", 32'(rsp_valid[0][0]), 32'd0);

      // Overflow and saturation corners
      op_test("sub_ovf", 0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
      op_test("add_ovf", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
      op_test("sub_nov", 1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);

      // Tie arbitration from reset
      do_reset();
      auto_ops = 1'b1;
      acc_log.delete();
      acc_cyc.delete();
      req_valid[0] = 1'b1;
      req_valid[1] = 1'b1;
      rsp_ready[0] = 1'b1;
      rsp_ready[1] = 1'b1;
      repeat (12) cyc();
      check("tie_count", 32'(acc_log.size() >= 4), 32'd1);
      if (acc_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("tie_order", 32'(acc_log[i]), 32'(i % 2));
         check("tie_b2b", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      end

      // Backpressure on response channel 1
      rsp_ready[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid[0][1]) break;
         cyc();
      end
      check("bp_rise", 32'(rsp_valid[0][1]), 32'd1);
      snap_sum  = rsp_sum[0][1];
      snap_cout = rsp_cout[0][1];
      snap_ovfl = rsp_ovfl[0][1];
      done0 = hs_cnt[0];
      done1 = hs_cnt[1];
      for (int i = 0; i < 10; i++) begin
         cyc();
         #1;
         check("bp_valid", 32'(rsp_valid[0][1]), 32'd1);
         check("bp_sum",   32'(rsp_sum[0][1]),   32'(snap_sum));
         check("bp_cout",  32'(rsp_cout[0][1]),  32'(snap_cout));
         check("bp_ovfl",  32'(rsp_ovfl[0][1]),  32'(snap_ovfl));
         check("bp_ready", 32'(rdy[0][1]),       32'd0);
      end
      check("bp_req0_progress", 32'(hs_cnt[0] - done0 >= 2), 32'd1);
      rsp_ready[1] = 1'b1;
      cyc();
      #1;
      check("bp_one_hs",     32'(hs_cnt[1] - done1), 32'd1);
      check("bp_valid_drop", 32'(rsp_valid[0][1]),   32'd0);
      check("bp_reeligible", 32'(rdy[0][1]),         32'd1);

      // Drain, then reset during requester 0's ISSUE cycle
      auto_ops = 1'b0;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      repeat (6) cyc();
      req_valid[0] = 1'b1;
      req_a[0] = 16'h1234;
      req_b[0] = 16'h1111;
      req_sub[0] = 1'b0;
      #1;
      check("mf_accept", 32'(rdy[0][0]), 32'd1);
      cyc();
      rst = 1'b1;
      req_valid[1] = 1'b1;
      #1;
      clear_sb();
      for (int d = 0; d < 2; d++) begin
         check("mf_rsp0_valid", 32'(rsp_valid[d][0]), 32'd0);
         check("mf_rsp1_valid", 32'(rsp_valid[d][1]), 32'd0);
         check("mf_ready0",     32'(rdy[d][0]),       32'd0);
         check("mf_ready1",     32'(rdy[d][1]),       32'd0);
         check("mf_add_a",      32'(add_a[d]),        32'd0);
      end
      cyc();
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("mf_tie_r0", 32'(rdy[d][0]), 32'd1);
         check("mf_tie_r1", 32'(rdy[d][1]), 32'd0);
      end
      cyc();
      #1;
      check("mf_no_stale", 32'(rsp_valid[0][0]), 32'd0);
      repeat (6) cyc();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin scheduler that time-shares one 16-bit carry-lookahead add/sub unit between two requesters. Each requester presents operands and an add/subtract select over a valid/ready handshake; the block registers the winning operation, drives it onto the shared adder, captures sum/carry/overflow, and returns the result on that requester's own valid/ready response channel. It sits between the datapath clients (e.g. sample accumulator and address/offset unit) and the single adder instance, which is external and purely combinational.

## Interface

- `SAT`, default 0: when 1, signed-overflowed results are saturated; when 0, the raw wrapped sum is returned.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle when high together with `req0_valid`.
- `req0_a` in 16: operand A.
- `req0_b` in 16: operand B.
- `req0_sub` in 1: 1 = A−B, 0 = A+B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0.
- `rsp0_valid` out 1: result for requester 0 held.
- `rsp0_ready` in 1: requester 0 consumes the result.
- `rsp0_sum` out 16: result.
- `rsp0_cout` out 1: adder carry-out.
- `rsp0_ovfl` out 1: signed overflow (raw flag from the adder, also set when saturated).
- `rsp1_valid`, `rsp1_ready`, `rsp1_sum`, `rsp1_cout`, `rsp1_ovfl`: same as requester 0.
- `add_a` out 16: to the adder's `a`.
- `add_b` out 16: to the adder's `b` (un-inverted; the adder inverts on sub).
- `add_sub` out 1: to the adder's `sub`.
- `add_sum` in 16, `add_cout` in 1, `add_ovfl` in 1: from the adder.

## Operation

- Per-requester state machine with states IDLE, ISSUE and RESP:
  - IDLE→ISSUE on accept (`reqN_valid & reqN_ready`).
  - ISSUE→RESP unconditionally after one cycle; the result is captured into the rspN registers.
  - RESP→IDLE on `rspN_valid & rspN_ready`.
- Each requester has at most one operation outstanding.
- A requester is eligible when its state is IDLE and its `reqN_valid` is high. Accept is also blocked if the other requester is in ISSUE; the single issue register must be free or freeing. Because an ISSUE lasts exactly one cycle, a back-to-back accept of the other requester in the ISSUE cycle is allowed.
- Arbitration is round-robin with a 1-bit `last` pointer, which names the requester accepted most recently:
  - Only one requester eligible: it wins.
  - Both eligible: the requester other than `last` wins.
  - `last` updates only on an accept.
- `reqN_ready` is a combinational function of state, `last` and both `reqN_valid`s. It is never high while its state is not IDLE. At most one ready is high per cycle.
- Issue register: `add_a`, `add_b` and `add_sub` are registered copies of the winner's operands, with an owner tag. They hold their last value when idle and are 0 after reset.
- Result capture at the end of ISSUE: `rspN_sum = add_sum`, `rspN_cout = add_cout`, `rspN_ovfl = add_ovfl`.
- When SAT=1 and `add_ovfl`=1, `rspN_sum` becomes 0x7FFF if `add_a[15]`=0, else 0x8000.
- rsp registers hold stable while RESP and `rspN_ready` is low.
- Reset values: all outputs 0. Both states IDLE, `last`=1 (so requester 0 wins the first tie), owner tag 0.
- Reset asserted mid-operation: in-flight and held results are discarded, and no response is produced for them.

## Timing

- Latency: accept in cycle N → `rspN_valid` high in cycle N+2 (N+1 is ISSUE, adder evaluated from registered operands).
- Earliest re-accept for the same requester: the cycle after its response handshake.
  - Single-requester throughput: 1 op / 3 cycles if `rsp_ready` is tied high.
  - Two requesters alternate, so the adder is busy up to 2 of every 3 cycles.
- Simultaneous events:
  - Response handshake of requester X in the same cycle as an accept of requester Y is legal.
  - Both responses may complete in the same cycle.
- The adder path must close in one cycle from the issue register to the rsp registers.

## Test plan

- Single op: reset, then req0 a=0x0003, b=0x0005, sub=0 with `rsp0_ready`=1 → `req0_ready` high in cycle 0; `rsp0_valid` in cycle 2 with sum=0x0008, cout=0, ovfl=0; `rsp0_valid` low in cycle 3.
- Subtract and overflow, SAT=0: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovfl=1, cout=1. With SAT=1: a=0x7FFF, b=0x0001, sub=0 → sum=0x7FFF, ovfl=1.
- Tie arbitration: after reset, both valid every cycle with responses always ready:
  - Accepts occur in order req0, req1, req0, req1.
  - req1's result follows req0's by one cycle.
  - Never two readies in one cycle.
- Backpressure: `rsp1_ready`=0 for 10 cycles after `rsp1_valid` rises → `rsp1` sum/flags stable and `req1_ready`=0 throughout, while req0 keeps completing ops. Raising `rsp1_ready` → one handshake, then req1 is eligible the next cycle.
- Reset mid-flight: assert `rst` during req0's ISSUE cycle → all valids and readies go 0 immediately. After release, no stale `rsp0_valid` appears and requester 0 wins the next tie.
